// File: rtl/uart_pkg.sv
// Shared definitions for the 16450-style UART: register offsets, LSR bit
// positions, IIR codes and the TX/RX state encodings.
package uart_pkg;

  localparam logic [2:0] REG_RBR = 3'd0;  // RBR/THR, DLL when DLAB=1
  localparam logic [2:0] REG_IER = 3'd1;  // IER, DLM when DLAB=1
  localparam logic [2:0] REG_IIR = 3'd2;
  localparam logic [2:0] REG_LCR = 3'd3;
  localparam logic [2:0] REG_MCR = 3'd4;  // reserved, reads 0
  localparam logic [2:0] REG_LSR = 3'd5;
  localparam logic [2:0] REG_MSR = 3'd6;  // reserved, reads 0
  localparam logic [2:0] REG_SCR = 3'd7;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_FE   = 3;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  localparam logic [7:0] IIR_NONE = 8'h01;
  localparam logic [7:0] IIR_THRE = 8'h02;
  localparam logic [7:0] IIR_RDA  = 8'h04;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Highest-priority pending interrupt: received data beats THR empty.
  function automatic logic [7:0] iir_code(input logic [1:0] ier,
                                          input logic dr,
                                          input logic thre);
    logic [7:0] code;
    if (ier[0] && dr) begin
      code = IIR_RDA;
    end else if (ier[1] && thre) begin
      code = IIR_THRE;
    end else begin
      code = IIR_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/uart_baudgen.sv
// 16x oversampling baud tick generator. Counts 0..div-1 and emits a one-clock
// tick on the wrap; a zero divisor halts ticking, clr restarts the count.
module uart_baudgen
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] div,
  input  logic        clr,
  output logic        tick
);

  logic [15:0] count_r;
  logic [15:0] count_n_s;
  logic        tick_r;
  logic        tick_n_s;

  // Next counter value and tick; >= keeps a shrunken divisor from overrunning.
  always_comb begin
    count_n_s = 16'd0;
    tick_n_s  = 1'b0;
    if (clr) begin
      count_n_s = 16'd0;
      tick_n_s  = 1'b0;
    end else if (div == 16'd0) begin
      count_n_s = 16'd0;
      tick_n_s  = 1'b0;
    end else if (count_r >= (div - 16'd1)) begin
      count_n_s = 16'd0;
      tick_n_s  = 1'b1;
    end else begin
      count_n_s = count_r + 16'd1;
      tick_n_s  = 1'b0;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 16'd0;
      tick_r  <= 1'b0;
    end else begin
      count_r <= count_n_s;
      tick_r  <= tick_n_s;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_16450.sv
// 16450-compatible UART register subset: fixed 8N1, single-byte THR/RBR,
// 16x oversampled receiver and a level interrupt, on the memory_io strobes.
module uart_16450
  import uart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       ce,
  input  logic       we,
  input  logic       re,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);

  logic       wr_s, rd_s, wr_prev_r, rd_prev_r, wr_edge_s, rd_edge_s;
  logic       dlab_s, thr_wr_s, dl_wr_s, rbr_rd_s, lsr_rd_s;
  logic [1:0] ier_r;
  logic [7:0] lcr_r, scr_r, dll_r, dlm_r, rbr_r, thr_r, lsr_s;
  logic       dr_r, oe_r, fe_r, thre_r, temt_s, irq_r, tick_s;

  tx_state_t  tx_state_r, tx_state_n_s;
  logic [3:0] tx_tcnt_r;
  logic [2:0] tx_bit_r;
  logic [7:0] tx_shift_r;
  logic       tx_r, tx_load_s;

  rx_state_t  rx_state_r, rx_state_n_s;
  logic       rx_meta_r, rx_sync_r, rx_load_s;
  logic [3:0] rx_tcnt_r;
  logic [2:0] rx_bit_r;
  logic [7:0] rx_shift_r;

  // Side effects fire only on the first clock of a qualified strobe.
  assign wr_s      = ce & we;
  assign rd_s      = ce & re;
  assign wr_edge_s = wr_s & ~wr_prev_r;
  assign rd_edge_s = rd_s & ~rd_prev_r;
  assign dlab_s    = lcr_r[7];
  assign thr_wr_s  = wr_edge_s & (addr == REG_RBR) & ~dlab_s;
  assign dl_wr_s   = wr_edge_s & dlab_s & ((addr == REG_RBR) | (addr == REG_IER));
  assign rbr_rd_s  = rd_edge_s & (addr == REG_RBR) & ~dlab_s;
  assign lsr_rd_s  = rd_edge_s & (addr == REG_LSR);
  assign temt_s    = thre_r & (tx_state_r == TX_IDLE);

  uart_baudgen u_baudgen (
    .clk   (clk),
    .rst_n (rst_n),
    .div   ({dlm_r, dll_r}),
    .clr   (dl_wr_s),
    .tick  (tick_s)
  );

  // Previous-strobe flags and the two-flop rx synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev_r <= 1'b0;
      rd_prev_r <= 1'b0;
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      wr_prev_r <= wr_s;
      rd_prev_r <= rd_s;
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Register writes, THR handshake, receive status flags and the interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ier_r  <= 2'd0;
      lcr_r  <= 8'd0;
      scr_r  <= 8'd0;
      dll_r  <= DEFAULT_DIV[7:0];
      dlm_r  <= DEFAULT_DIV[15:8];
      thr_r  <= 8'd0;
      thre_r <= 1'b1;
      rbr_r  <= 8'd0;
      dr_r   <= 1'b0;
      oe_r   <= 1'b0;
      fe_r   <= 1'b0;
      irq_r  <= 1'b0;
    end else begin
      if (wr_edge_s) begin
        case (addr)
          REG_RBR: if (dlab_s) dll_r <= wdata;
          REG_IER: if (dlab_s) dlm_r <= wdata; else ier_r <= wdata[1:0];
          REG_LCR: lcr_r <= wdata;
          REG_SCR: scr_r <= wdata;
          default: ;
        endcase
      end
      // A write while THRE=0 (including the transfer clock) is dropped.
      if (tx_load_s) begin
        thre_r <= 1'b1;
      end else if (thr_wr_s && thre_r) begin
        thr_r  <= wdata;
        thre_r <= 1'b0;
      end
      // A completing frame beats a same-clock RBR/LSR read.
      if (rx_load_s) begin
        rbr_r <= rx_shift_r;
        dr_r  <= 1'b1;
      end else if (rbr_rd_s) begin
        dr_r  <= 1'b0;
      end
      if (rx_load_s && dr_r) oe_r <= 1'b1;
      else if (lsr_rd_s)     oe_r <= 1'b0;
      if (rx_load_s && !rx_sync_r) fe_r <= 1'b1;
      else if (lsr_rd_s)           fe_r <= 1'b0;
      irq_r <= (ier_r[0] & dr_r) | (ier_r[1] & thre_r);
    end
  end

  // TX next-state logic.
  always_comb begin
    tx_state_n_s = tx_state_r;
    tx_load_s    = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        if (!thre_r) begin
          tx_state_n_s = TX_START;
          tx_load_s    = 1'b1;
        end else begin
          tx_state_n_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (tick_s && (tx_tcnt_r == 4'd15)) tx_state_n_s = TX_DATA;
        else tx_state_n_s = TX_START;
      end
      TX_DATA: begin
        if (tick_s && (tx_tcnt_r == 4'd15) && (tx_bit_r == 3'd7)) tx_state_n_s = TX_STOP;
        else tx_state_n_s = TX_DATA;
      end
      TX_STOP: begin
        if (tick_s && (tx_tcnt_r == 4'd15)) tx_state_n_s = TX_IDLE;
        else tx_state_n_s = TX_STOP;
      end
      default: tx_state_n_s = TX_IDLE;
    endcase
  end

  // TX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state_r <= TX_IDLE;
    else        tx_state_r <= tx_state_n_s;
  end

  // TX shifter and line driver; tx_r always holds the bit now on the wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_tcnt_r  <= 4'd0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      tx_r       <= 1'b1;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          tx_tcnt_r <= 4'd0;
          tx_bit_r  <= 3'd0;
          if (tx_load_s) begin
            tx_shift_r <= thr_r;
            tx_r       <= 1'b0;
          end else begin
            tx_r       <= 1'b1;
          end
        end
        default: begin
          if (tick_s) begin
            tx_tcnt_r <= tx_tcnt_r + 4'd1;
            if (tx_tcnt_r == 4'd15) begin
              if (tx_state_r == TX_START) begin
                tx_r <= tx_shift_r[0];
              end else if ((tx_state_r == TX_DATA) && (tx_bit_r != 3'd7)) begin
                tx_r       <= tx_shift_r[1];
                tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                tx_bit_r   <= tx_bit_r + 3'd1;
              end else begin
                tx_r <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  // RX next-state logic; the start bit is re-checked at mid-bit.
  always_comb begin
    rx_state_n_s = rx_state_r;
    rx_load_s    = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (!rx_sync_r) rx_state_n_s = RX_START;
        else rx_state_n_s = RX_IDLE;
      end
      RX_START: begin
        if (tick_s && (rx_tcnt_r == 4'd7)) rx_state_n_s = rx_sync_r ? RX_IDLE : RX_DATA;
        else rx_state_n_s = RX_START;
      end
      RX_DATA: begin
        if (tick_s && (rx_tcnt_r == 4'd15) && (rx_bit_r == 3'd7)) rx_state_n_s = RX_STOP;
        else rx_state_n_s = RX_DATA;
      end
      RX_STOP: begin
        if (tick_s && (rx_tcnt_r == 4'd15)) begin
          rx_state_n_s = RX_IDLE;
          rx_load_s    = 1'b1;
        end else begin
          rx_state_n_s = RX_STOP;
        end
      end
      default: rx_state_n_s = RX_IDLE;
    endcase
  end

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state_r <= RX_IDLE;
    else        rx_state_r <= rx_state_n_s;
  end

  // RX tick/bit counters and data shifter (LSB arrives first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_tcnt_r  <= 4'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
    end else begin
      case (rx_state_r)
        RX_IDLE: begin
          rx_tcnt_r <= 4'd0;
          rx_bit_r  <= 3'd0;
        end
        RX_START: begin
          if (tick_s) rx_tcnt_r <= (rx_tcnt_r == 4'd7) ? 4'd0 : rx_tcnt_r + 4'd1;
        end
        RX_DATA: begin
          if (tick_s) begin
            rx_tcnt_r <= rx_tcnt_r + 4'd1;
            if (rx_tcnt_r == 4'd15) begin
              rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
              rx_bit_r   <= rx_bit_r + 3'd1;
            end
          end
        end
        default: begin
          if (tick_s) rx_tcnt_r <= rx_tcnt_r + 4'd1;
        end
      endcase
    end
  end

  // Line status assembly.
  always_comb begin
    lsr_s           = 8'h00;
    lsr_s[LSR_DR]   = dr_r;
    lsr_s[LSR_OE]   = oe_r;
    lsr_s[LSR_FE]   = fe_r;
    lsr_s[LSR_THRE] = thre_r;
    lsr_s[LSR_TEMT] = temt_s;
  end

  // Read mux: purely a function of addr and DLAB, no side effects.
  always_comb begin
    rdata = 8'h00;
    case (addr)
      REG_RBR: rdata = dlab_s ? dll_r : rbr_r;
      REG_IER: rdata = dlab_s ? dlm_r : {6'd0, ier_r};
      REG_IIR: rdata = iir_code(ier_r, dr_r, thre_r);
      REG_LCR: rdata = lcr_r;
      REG_MCR: rdata = 8'h00;
      REG_LSR: rdata = lsr_s;
      REG_MSR: rdata = 8'h00;
      REG_SCR: rdata = scr_r;
      default: rdata = 8'h00;
    endcase
  end

  assign tx  = tx_r;
  assign irq = irq_r;

endmodule

// File: tb/tb_uart_16450.sv
// Directed and randomized bench for uart_16450. A line-level frame monitor
// and a flag model of the receive status are kept inside the bench.
module tb_uart_16450;

  logic       clk = 1'b0;
  logic       rst_n, ce, we, re, rx, tx, irq;
  logic [2:0] addr;
  logic [7:0] wdata, rdata;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int bit_clks = 16;

  // Frames seen on tx: {start, stop, data}, with start-detect cycle.
  logic [9:0] fq[$];
  int         tq[$];

  // Reference model of the register-visible receive state.
  logic       m_dr = 1'b0, m_oe = 1'b0, m_fe = 1'b0, m_dlab = 1'b0;
  logic [7:0] m_rbr = 8'h00;
  logic [1:0] m_ier = 2'b00;

  uart_16450 #(.DEFAULT_DIV(16'd27)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .rdata(rdata),
    .ce(ce), .we(we), .re(re), .rx(rx), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Decode frames on the tx line by mid-bit sampling.
  initial begin : tx_mon
    logic [7:0] d;
    logic sb, st;
    int t0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        t0 = cyc;
        repeat (bit_clks / 2) @(negedge clk);
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (bit_clks) @(negedge clk);
          d[i] = tx;
        end
        repeat (bit_clks) @(negedge clk);
        st = tx;
        fq.push_back({sb, st, d});
        tq.push_back(t0);
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_lsr(input logic temt, input logic thre);
    return {1'b0, temt, thre, 1'b0, m_fe, 1'b0, m_oe, m_dr};
  endfunction

  function automatic logic [7:0] exp_iir(input logic thre);
    if (m_ier[0] && m_dr) return 8'h04;
    else if (m_ier[1] && thre) return 8'h02;
    else return 8'h01;
  endfunction

  function automatic logic exp_irq(input logic thre);
    return (m_ier[0] & m_dr) | (m_ier[1] & thre);
  endfunction

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input int hold = 1);
    @(negedge clk);
    addr = a; wdata = d; ce = 1'b1; we = 1'b1;
    repeat (hold) @(negedge clk);
    ce = 1'b0; we = 1'b0;
    if (a == 3'd3) m_dlab = d[7];
    if (a == 3'd1 && !m_dlab) m_ier = d[1:0];
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; ce = 1'b1; re = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    ce = 1'b0; re = 1'b0;
    if (a == 3'd0 && !m_dlab) m_dr = 1'b0;
    if (a == 3'd5) begin m_oe = 1'b0; m_fe = 1'b0; end
  endtask

  task automatic peek(input logic [2:0] a, output logic [7:0] d);
    addr = a;
    #1 d = rdata;
  endtask

  task automatic set_div(input logic [15:0] dv);
    wr(3'd3, 8'h80);
    wr(3'd0, dv[7:0]);
    wr(3'd1, dv[15:8]);
    wr(3'd3, 8'h03);
    bit_clks = 16 * int'(dv);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] line;
    line = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = line[i];
      repeat (bit_clks - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = 1'b1;
    m_oe  = m_oe | m_dr;
    m_dr  = 1'b1;
    m_rbr = b;
    if (!stop) m_fe = 1'b1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (fq.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("frame_count", 32'(fq.size()), 32'(n));
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [9:0] f;
    if (fq.size() > 0) begin
      f = fq.pop_front();
      void'(tq.pop_front());
      chk(tag, 32'(f), 32'({1'b0, 1'b1, b}));
    end else begin
      chk(tag, 32'hffff_ffff, 32'({1'b0, 1'b1, b}));
    end
  endtask

  initial begin : main
    logic [7:0] v, b, e;
    logic       sb;
    int         gap;

    rst_n = 1'b0; ce = 1'b0; we = 1'b0; re = 1'b0; rx = 1'b1;
    addr = 3'd0; wdata = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    peek(3'd5, v); chk("rst_lsr", 32'(v), 32'(8'h60));
    peek(3'd2, v); chk("rst_iir", 32'(v), 32'(8'h01));
    chk("rst_tx", 32'(tx), 32'(1'b1));
    chk("rst_irq", 32'(irq), 32'(1'b0));
    wr(3'd3, 8'h80);
    peek(3'd0, v); chk("rst_dll", 32'(v), 32'(8'h1b));
    peek(3'd1, v); chk("rst_dlm", 32'(v), 32'(8'h00));

    // Divisor 1, 8N1
    set_div(16'd1);
    peek(3'd3, v); chk("lcr_rb", 32'(v), 32'(8'h03));

    // Single TX frame and THRE/TEMT timing
    wr(3'd0, 8'hA5);
    peek(3'd5, v); chk("thre_clr", 32'(v), 32'(exp_lsr(1'b0, 1'b0)));
    @(negedge clk);
    peek(3'd5, v); chk("thre_set", 32'(v), 32'(exp_lsr(1'b0, 1'b1)));
    wait_frames(1, 12 * bit_clks);
    check_frame("tx_a5", 8'hA5);
    repeat (12) @(negedge clk);
    peek(3'd5, v); chk("temt_after", 32'(v), 32'(exp_lsr(1'b1, 1'b1)));

    // Strobe held for several clocks is a single write
    wr(3'd0, 8'h3A, 4);
    wait_frames(1, 12 * bit_clks);
    check_frame("tx_hold", 8'h3A);
    repeat (2 * 10 * bit_clks) @(negedge clk);
    chk("hold_one_frame", 32'(fq.size()), 32'd0);

    // Back-to-back frames, third write dropped
    wr(3'd0, 8'h55);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      peek(3'd5, v);
      if (v[5]) break;
    end
    wr(3'd0, 8'h0F);
    wr(3'd0, 8'hAA);
    wait_frames(2, 24 * bit_clks);
    if (tq.size() >= 2) begin
      gap = tq[1] - tq[0];
      chk("b2b_no_idle_bit", 32'(gap >= 10 * bit_clks && gap < 11 * bit_clks), 32'd1);
    end
    check_frame("tx_55", 8'h55);
    check_frame("tx_0f", 8'h0F);
    repeat (15 * bit_clks) @(negedge clk);
    chk("third_dropped", 32'(fq.size()), 32'd0);

    // RX 0x3C with receive interrupt
    wr(3'd1, 8'h01);
    send_rx(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    peek(3'd5, v); chk("rx_lsr", 32'(v), 32'(exp_lsr(1'b1, 1'b1)));
    peek(3'd0, v); chk("rx_rbr", 32'(v), 32'(m_rbr));
    chk("rx_irq", 32'(irq), 32'(exp_irq(1'b1)));
    peek(3'd2, v); chk("rx_iir", 32'(v), 32'(exp_iir(1'b1)));
    e = m_rbr;
    rd(3'd0, v); chk("rbr_read", 32'(v), 32'(e));
    repeat (2) @(negedge clk);
    chk("irq_clr", 32'(irq), 32'(exp_irq(1'b1)));
    peek(3'd5, v); chk("dr_clr", 32'(v), 32'(exp_lsr(1'b1, 1'b1)));

    // Overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    peek(3'd5, v); chk("oe_lsr", 32'(v), 32'(exp_lsr(1'b1, 1'b1)));
    peek(3'd0, v); chk("oe_rbr", 32'(v), 32'(m_rbr));
    e = exp_lsr(1'b1, 1'b1);
    rd(3'd5, v); chk("oe_lsr_read", 32'(v), 32'(e));
    peek(3'd5, v); chk("oe_cleared", 32'(v), 32'(exp_lsr(1'b1, 1'b1)));
    e = m_rbr;
    rd(3'd0, v); chk("oe_rbr_read", 32'(v), 32'(e));

    // False start glitch
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    peek(3'd5, v); chk("glitch_no_dr", 32'(v), 32'(exp_lsr(1'b1, 1'b1)));

    // Framing error
    send_rx(8'h81, 1'b0);
    repeat (30) @(negedge clk);
    peek(3'd5, v); chk("fe_lsr", 32'(v), 32'(exp_lsr(1'b1, 1'b1)));
    peek(3'd0, v); chk("fe_rbr", 32'(v), 32'(m_rbr));
    e = exp_lsr(1'b1, 1'b1);
    rd(3'd5, v); chk("fe_lsr_read", 32'(v), 32'(e));
    peek(3'd5, v); chk("fe_cleared", 32'(v), 32'(exp_lsr(1'b1, 1'b1)));
    rd(3'd0, v);

    // IER masking, THRE interrupt, SCR
    wr(3'd1, 8'hFF);
    peek(3'd1, v); chk("ier_mask", 32'(v), 32'(8'h03));
    repeat (3) @(negedge clk);
    chk("thre_irq", 32'(irq), 32'(exp_irq(1'b1)));
    peek(3'd2, v); chk("thre_iir", 32'(v), 32'(exp_iir(1'b1)));
    b = 8'($urandom_range(0, 255));
    wr(3'd7, b);
    peek(3'd7, v); chk("scr_rw", 32'(v), 32'(b));
    wr(3'd1, 8'h00);

    // Randomized RX traffic against the flag model
    for (int i = 0; i < 5; i++) begin
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      send_rx(b, sb);
      repeat (30) @(negedge clk);
      peek(3'd5, v); chk("rnd_rx_lsr", 32'(v), 32'(exp_lsr(1'b1, 1'b1)));
      peek(3'd0, v); chk("rnd_rx_rbr", 32'(v), 32'(m_rbr));
      if ($urandom_range(0, 1) == 1) begin
        e = exp_lsr(1'b1, 1'b1);
        rd(3'd5, v); chk("rnd_rx_lsr_rd", 32'(v), 32'(e));
        e = m_rbr;
        rd(3'd0, v); chk("rnd_rx_rbr_rd", 32'(v), 32'(e));
      end
    end
    rd(3'd5, v);
    rd(3'd0, v);

    // Randomized TX bytes at divisors 1 and 2, plus one RX at that rate
    for (int i = 0; i < 3; i++) begin
      set_div(16'($urandom_range(1, 2)));
      b = 8'($urandom_range(0, 255));
      wr(3'd0, b);
      wait_frames(1, 12 * bit_clks + 40);
      check_frame("rnd_tx", b);
      repeat (bit_clks) @(negedge clk);
      b = 8'($urandom_range(0, 255));
      send_rx(b, 1'b1);
      repeat (3 * bit_clks) @(negedge clk);
      e = m_rbr;
      rd(3'd0, v); chk("rnd_div_rx", 32'(v), 32'(e));
    end

    // Reset in the middle of a TX frame
    set_div(16'd1);
    wr(3'd0, 8'hA5);
    repeat (40) @(negedge clk);
    chk("tx_before_rst", 32'(tx), 32'(1'b0));
    #2 rst_n = 1'b0;
    #1 chk("tx_async_rst", 32'(tx), 32'(1'b1));
    m_dr = 1'b0; m_oe = 1'b0; m_fe = 1'b0; m_rbr = 8'h00; m_ier = 2'b00; m_dlab = 1'b0;
    peek(3'd5, v); chk("rst_mid_lsr", 32'(v), 32'(exp_lsr(1'b1, 1'b1)));
    peek(3'd3, v); chk("rst_mid_lcr", 32'(v), 32'(8'h00));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wr(3'd3, 8'h80);
    peek(3'd0, v); chk("rst_mid_dll", 32'(v), 32'(8'h1b));
    peek(3'd1, v); chk("rst_mid_dlm", 32'(v), 32'(8'h00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
